// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source encoding for the fetch address generator.
package pc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        RESET,
        TRAP,
        MISALIGN,
        REDIRECT,
        RAS,
        SEQ,
        HOLD
    } next_pc_sel_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: saturating count, the oldest entry is overwritten on overflow.
module return_address_stack
    import pc_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] entries_q [RAS_DEPTH];
    logic [WIDTH-1:0] entries_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next free slot, so the top lives one slot below it.
    assign top_idx = ptr_q - 1'b1;
    assign top     = entries_q[top_idx];
    assign empty   = (count_q == '0);

    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        if (push && pop) begin
            entries_d[top_idx] = push_data;
        end else if (push) begin
            entries_d[ptr_q] = push_data;
            ptr_d            = ptr_q + 1'b1;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
        entries_q <= entries_d;
    end

endmodule

// File: rtl/pc_generator.sv
// Fetch-address generator: holds the fetch PC, handles stall, redirect, trap and
// misaligned targets, and predicts returns through a small return-address stack.
module pc_generator
    import pc_pkg::*;
#(
    parameter int               WIDTH        = XLEN,
    parameter logic [WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_epc,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc_out,
    output logic             misalign_err,
    output logic             ras_empty
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             valid_q, valid_d;
    logic             misalign_q, misalign_d;

    logic             accept;
    logic             target_misaligned;
    logic             ras_push_en, ras_pop_en;
    logic [WIDTH-1:0] ras_top;
    logic             ras_is_empty;
    next_pc_sel_e     sel;

    assign accept            = valid_q & fetch_ready & ~stall;
    assign target_misaligned = (redirect_target[1:0] != 2'b00);
    assign pc_plus4          = pc_q + WIDTH'(INSTR_BYTES);

    // A redirect or trap squashes the fetch it lands on, including its RAS effect.
    assign ras_push_en = accept & ras_push & ~trap_valid & ~redirect_valid;
    assign ras_pop_en  = accept & ras_pop & ~trap_valid & ~redirect_valid;

    always_comb begin
        if (reset)                                  sel = RESET;
        else if (trap_valid)                        sel = TRAP;
        else if (redirect_valid && target_misaligned) sel = MISALIGN;
        else if (redirect_valid)                    sel = REDIRECT;
        else if (accept && ras_pop && !ras_is_empty) sel = RAS;
        else if (accept)                            sel = SEQ;
        else                                        sel = HOLD;
    end

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        valid_d    = 1'b1;
        misalign_d = 1'b0;
        case (sel)
            RESET: begin
                pc_d    = RESET_VECTOR;
                epc_d   = '0;
                valid_d = 1'b0;
            end
            TRAP: begin
                pc_d  = TRAP_VECTOR;
                epc_d = trap_epc;
            end
            MISALIGN: begin
                pc_d       = TRAP_VECTOR;
                epc_d      = redirect_target;
                misalign_d = 1'b1;
            end
            REDIRECT: pc_d = redirect_target;
            RAS:      pc_d = ras_top;
            SEQ:      pc_d = pc_plus4;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    return_address_stack #(
        .WIDTH    (WIDTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push_en),
        .pop      (ras_pop_en),
        .push_data(pc_plus4),
        .top      (ras_top),
        .empty    (ras_is_empty)
    );

    assign pc_valid     = valid_q;
    assign pc_out       = pc_q;
    assign epc_out      = epc_q;
    assign misalign_err = misalign_q;
    assign ras_empty    = ras_is_empty;

endmodule

// File: tb/tb_pc_generator.sv
// Directed and randomized bench for pc_generator against a queue-based reference model.
module tb_pc_generator;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, redirect_valid, trap_valid, ras_push, ras_pop;
    logic [31:0] redirect_target, trap_epc;
    logic        pc_valid, misalign_err, ras_empty;
    logic [31:0] pc_out, pc_plus4, epc_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_valid, m_mis;
    logic [31:0] m_ras [$];

    pc_generator #(
        .WIDTH(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_epc(trap_epc),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_valid(pc_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .epc_out(epc_out), .misalign_err(misalign_err), .ras_empty(ras_empty)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; fetch_ready = 0; redirect_valid = 0; redirect_target = '0;
        trap_valid = 0; trap_epc = '0; ras_push = 0; ras_pop = 0;
    endtask

    // Reference model: one clock edge of the specified next-PC rules.
    task automatic model_edge();
        logic        acc;
        logic [31:0] n_pc;
        logic        n_mis;
        if (reset) begin
            m_pc = RV; m_valid = 0; m_epc = 0; m_mis = 0;
            m_ras.delete();
            return;
        end
        acc   = m_valid && fetch_ready && !stall;
        n_pc  = m_pc;
        n_mis = 0;
        if (trap_valid) begin
            n_pc = TV; m_epc = trap_epc;
        end else if (redirect_valid && (redirect_target % 4 != 0)) begin
            n_pc = TV; m_epc = redirect_target; n_mis = 1;
        end else if (redirect_valid) begin
            n_pc = redirect_target;
        end else if (acc) begin
            if (ras_pop && m_ras.size() > 0) n_pc = m_ras[$];
            else n_pc = m_pc + 32'd4;
            if (ras_push && ras_pop) begin
                if (m_ras.size() > 0) m_ras[$] = m_pc + 32'd4;
            end else if (ras_push) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (ras_pop && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        m_pc = n_pc; m_mis = n_mis; m_valid = 1;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("epc_out", epc_out, m_epc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
    endtask

    task automatic jump(input logic [31:0] tgt);
        idle(); fetch_ready = 1; redirect_valid = 1; redirect_target = tgt; cycle();
    endtask

    task automatic call_at(input logic [31:0] pc);
        jump(pc);
        idle(); fetch_ready = 1; ras_push = 1; cycle();
    endtask

    initial begin
        idle();
        // Reset and free run
        reset = 1; cycle(); cycle();
        chk("reset_pc", pc_out, RV);
        chk("reset_valid", {31'd0, pc_valid}, 32'd0);
        chk("reset_ras_empty", {31'd0, ras_empty}, 32'd1);
        idle(); fetch_ready = 1;
        cycle(); chk("run0", pc_out, 32'd0);
        chk("valid_after_reset", {31'd0, pc_valid}, 32'd1);
        cycle(); chk("run4", pc_out, 32'd4);
        cycle(); chk("run8", pc_out, 32'd8);
        // Stall, then backpressure
        stall = 1; repeat (3) cycle();
        chk("stall_hold", pc_out, 32'd8);
        stall = 0; fetch_ready = 0; repeat (2) cycle();
        chk("bp_hold", pc_out, 32'd8);
        fetch_ready = 1; cycle(); chk("resume12", pc_out, 32'd12);

        // Redirect and trap priority
        jump(32'h200); chk("redirect", pc_out, 32'h200);
        idle(); redirect_valid = 1; redirect_target = 32'h300; trap_valid = 1; trap_epc = 32'h40;
        cycle(); chk("trap_pc", pc_out, 32'h100); chk("trap_epc", epc_out, 32'h40);

        // Misaligned redirect
        jump(32'h202);
        chk("mis_pc", pc_out, 32'h100); chk("mis_epc", epc_out, 32'h202);
        chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
        idle(); cycle(); chk("mis_clear", {31'd0, misalign_err}, 32'd0);

        // RAS overflow and drain
        call_at(32'h10); call_at(32'h20); call_at(32'h30); call_at(32'h40); call_at(32'h50);
        idle(); fetch_ready = 1; ras_pop = 1;
        cycle(); chk("pop1", pc_out, 32'h54);
        cycle(); chk("pop2", pc_out, 32'h44);
        cycle(); chk("pop3", pc_out, 32'h34);
        cycle(); chk("pop4", pc_out, 32'h24);
        chk("drained", {31'd0, ras_empty}, 32'd1);
        cycle(); chk("pop_empty_seq", pc_out, 32'h28);

        // Tail call: push and pop together
        call_at(32'h20);
        jump(32'h80);
        idle(); fetch_ready = 1; ras_push = 1; ras_pop = 1;
        cycle(); chk("tail_pc", pc_out, 32'h24);
        idle(); fetch_ready = 1; ras_pop = 1;
        cycle(); chk("tail_top", pc_out, 32'h84);

        // Address wrap, then reset while the RAS holds entries
        jump(32'hFFFF_FFFC); chk("wrap_plus4", pc_plus4, 32'h0);
        idle(); fetch_ready = 1; cycle(); chk("wrap_pc", pc_out, 32'h0);
        call_at(32'h60);
        chk("ras_loaded", {31'd0, ras_empty}, 32'd0);
        idle(); reset = 1; trap_valid = 1; trap_epc = 32'h99; redirect_valid = 1; redirect_target = 32'h400;
        cycle();
        chk("midreset_pc", pc_out, RV);
        chk("midreset_ras", {31'd0, ras_empty}, 32'd1);
        chk("midreset_epc", epc_out, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            reset       = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 9) < 2);
            fetch_ready = ($urandom_range(0, 9) < 8);
            trap_valid  = ($urandom_range(0, 29) == 0);
            trap_epc    = $urandom;
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = {20'h0, 10'($urandom_range(0, 1023)),
                               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            ras_push = ($urandom_range(0, 4) == 0);
            ras_pop  = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
